// File: rtl/regfile_2r1w_if.sv
// Bus bundle for the 2-read/1-write register file: one byte-masked write port,
// two independent read ports and an address-error strobe.
interface regfile_2r1w_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = WIDTH / 8;

  logic             write_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [BW-1:0]    wr_be;
  logic             clear_all;
  logic             rd_en_a;
  logic [AW-1:0]    rd_addr_a;
  logic             rd_en_b;
  logic [AW-1:0]    rd_addr_b;
  logic [WIDTH-1:0] rd_data_a;
  logic             rd_valid_a;
  logic [WIDTH-1:0] rd_data_b;
  logic             rd_valid_b;
  logic             addr_err;

  modport master (
    output write_en, wr_addr, wr_data, wr_be, clear_all,
    output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    input  rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, addr_err
  );

  modport slave (
    input  write_en, wr_addr, wr_data, wr_be, clear_all,
    input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    output rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, addr_err
  );
endinterface

// File: rtl/regfile_2r1w.sv
// DEPTH x WIDTH register file, one byte-masked write port and two registered
// write-first read ports, with bulk clear and out-of-range detection.
module regfile_2r1w #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  regfile_2r1w_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = WIDTH / 8;
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [WIDTH-1:0] r_rd_data_a_p1;
  logic [WIDTH-1:0] r_rd_data_b_p1;
  logic             r_vld_a_p1;
  logic             r_vld_b_p1;
  logic             r_addr_err_p1;

  logic             w_wr_in_range;
  logic             w_ra_in_range;
  logic             w_rb_in_range;
  logic             w_wr_do;
  logic [WIDTH-1:0] w_wr_word;
  logic [WIDTH-1:0] w_rd_word_a;
  logic [WIDTH-1:0] w_rd_word_b;
  logic             w_addr_err;

  function automatic logic in_range(input logic [AW-1:0] addr);
    return {1'b0, addr} < DEPTH_L;
  endfunction

  function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] old_w,
                                                   input logic [WIDTH-1:0] new_w,
                                                   input logic [BW-1:0]    be);
    logic [WIDTH-1:0] res;
    res = old_w;
    for (int k = 0; k < BW; k++) begin
      if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

  // Read value as seen after this edge's clear/write: clear wins, then the
  // merged write word is forwarded on an address match (write-first).
  function automatic logic [WIDTH-1:0] read_word(input logic [AW-1:0]    addr,
                                                 input logic             addr_ok,
                                                 input logic             clr,
                                                 input logic             wr_do,
                                                 input logic [AW-1:0]    wr_addr,
                                                 input logic [WIDTH-1:0] wr_word,
                                                 input logic [WIDTH-1:0] stored);
    if (clr || !addr_ok) return '0;
    if (wr_do && (addr == wr_addr)) return wr_word;
    return stored;
  endfunction

  always_comb begin
    w_wr_in_range = in_range(bus.wr_addr);
    w_ra_in_range = in_range(bus.rd_addr_a);
    w_rb_in_range = in_range(bus.rd_addr_b);
    w_wr_do       = bus.write_en && !bus.clear_all && w_wr_in_range;
    w_wr_word     = merge_bytes(r_mem[bus.wr_addr], bus.wr_data, bus.wr_be);
    w_rd_word_a   = read_word(bus.rd_addr_a, w_ra_in_range, bus.clear_all, w_wr_do,
                              bus.wr_addr, w_wr_word, r_mem[bus.rd_addr_a]);
    w_rd_word_b   = read_word(bus.rd_addr_b, w_rb_in_range, bus.clear_all, w_wr_do,
                              bus.wr_addr, w_wr_word, r_mem[bus.rd_addr_b]);
    w_addr_err    = (bus.write_en && !w_wr_in_range) ||
                    (bus.rd_en_a  && !w_ra_in_range) ||
                    (bus.rd_en_b  && !w_rb_in_range);
  end

  // Stage p0 -> p1: array update and registered read ports
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_data_a_p1 <= '0;
      r_rd_data_b_p1 <= '0;
      r_vld_a_p1     <= 1'b0;
      r_vld_b_p1     <= 1'b0;
      r_addr_err_p1  <= 1'b0;
    end else begin
      if (bus.clear_all) begin
        for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_wr_do) begin
        r_mem[bus.wr_addr] <= w_wr_word;
      end
      if (bus.rd_en_a) r_rd_data_a_p1 <= w_rd_word_a;
      if (bus.rd_en_b) r_rd_data_b_p1 <= w_rd_word_b;
      r_vld_a_p1    <= bus.rd_en_a;
      r_vld_b_p1    <= bus.rd_en_b;
      r_addr_err_p1 <= w_addr_err;
    end
  end

  assign bus.rd_data_a  = r_rd_data_a_p1;
  assign bus.rd_data_b  = r_rd_data_b_p1;
  assign bus.rd_valid_a = r_vld_a_p1;
  assign bus.rd_valid_b = r_vld_b_p1;
  assign bus.addr_err   = r_addr_err_p1;
endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w (WIDTH=32, DEPTH=12): directed vector table followed
// by random traffic checked against an array-based reference model.
module tb_regfile_2r1w;
  localparam int WIDTH = 32;
  localparam int DEPTH = 12;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  regfile_2r1w_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  regfile_2r1w #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic          rst_n;
    logic          we;
    logic [AW-1:0] wa;
    logic [31:0]   wd;
    logic [3:0]    be;
    logic          clr;
    logic          rea;
    logic [AW-1:0] ra;
    logic          reb;
    logic [AW-1:0] rb;
    logic [31:0]   ea;
    logic [31:0]   eb;
    logic          eva;
    logic          evb;
    logic          eerr;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_a, m_b;
  logic        m_va, m_vb, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference: next array contents from clear/write rules, then reads see that array.
  task automatic model_step(input vec_t v);
    logic [31:0] nxt [DEPTH];
    if (!v.rst_n) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_a = '0; m_b = '0; m_va = 0; m_vb = 0; m_err = 0;
      return;
    end
    nxt = m_mem;
    if (v.clr) begin
      for (int i = 0; i < DEPTH; i++) nxt[i] = '0;
    end else if (v.we && int'(v.wa) < DEPTH) begin
      for (int k = 0; k < 4; k++)
        if (v.be[k]) nxt[v.wa][8*k +: 8] = v.wd[8*k +: 8];
    end
    if (v.rea) m_a = (int'(v.ra) < DEPTH) ? nxt[v.ra] : 32'h0;
    if (v.reb) m_b = (int'(v.rb) < DEPTH) ? nxt[v.rb] : 32'h0;
    m_va  = v.rea;
    m_vb  = v.reb;
    m_err = (v.we && int'(v.wa) >= DEPTH) || (v.rea && int'(v.ra) >= DEPTH) ||
            (v.reb && int'(v.rb) >= DEPTH);
    m_mem = nxt;
  endtask

  task automatic apply(input vec_t v, input bit use_table, input string tag);
    @(negedge clk);
    reset_n       = v.rst_n;
    bus.write_en  = v.we;
    bus.wr_addr   = v.wa;
    bus.wr_data   = v.wd;
    bus.wr_be     = v.be;
    bus.clear_all = v.clr;
    bus.rd_en_a   = v.rea;
    bus.rd_addr_a = v.ra;
    bus.rd_en_b   = v.reb;
    bus.rd_addr_b = v.rb;
    model_step(v);
    @(posedge clk);
    #1;
    if (use_table) begin
      chk({tag, ".rd_data_a"},  bus.rd_data_a,  v.ea);
      chk({tag, ".rd_data_b"},  bus.rd_data_b,  v.eb);
      chk({tag, ".rd_valid_a"}, 32'(bus.rd_valid_a), 32'(v.eva));
      chk({tag, ".rd_valid_b"}, 32'(bus.rd_valid_b), 32'(v.evb));
      chk({tag, ".addr_err"},   32'(bus.addr_err),   32'(v.eerr));
    end else begin
      chk({tag, ".rd_data_a"},  bus.rd_data_a,  m_a);
      chk({tag, ".rd_data_b"},  bus.rd_data_b,  m_b);
      chk({tag, ".rd_valid_a"}, 32'(bus.rd_valid_a), 32'(m_va));
      chk({tag, ".rd_valid_b"}, 32'(bus.rd_valid_b), 32'(m_vb));
      chk({tag, ".addr_err"},   32'(bus.addr_err),   32'(m_err));
    end
  endtask

  function automatic vec_t mk(logic rst_n, logic we, logic [AW-1:0] wa, logic [31:0] wd,
                              logic [3:0] be, logic clr, logic rea, logic [AW-1:0] ra,
                              logic reb, logic [AW-1:0] rb, logic [31:0] ea,
                              logic [31:0] eb, logic eva, logic evb, logic eerr);
    vec_t v;
    v.rst_n = rst_n; v.we = we; v.wa = wa; v.wd = wd; v.be = be; v.clr = clr;
    v.rea = rea; v.ra = ra; v.reb = reb; v.rb = rb;
    v.ea = ea; v.eb = eb; v.eva = eva; v.evb = evb; v.eerr = eerr;
    return v;
  endfunction

  vec_t tab [$];

  initial begin
    vec_t v;
    reset_n = 1'b0;
    bus.write_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = '0;
    bus.clear_all = 0; bus.rd_en_a = 0; bus.rd_addr_a = '0;
    bus.rd_en_b = 0; bus.rd_addr_b = '0;

    //            rst we wa  wd            be    clr rea ra  reb rb   ea            eb            va vb err
    tab.push_back(mk(0, 0, 0, 32'h0,        4'h0, 0, 0, 0,  0, 0,  32'h0,        32'h0,        0, 0, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,        4'h0, 0, 0, 0,  0, 0,  32'h0,        32'h0,        0, 0, 0));
    tab.push_back(mk(1, 0, 0, 32'h0,        4'h0, 0, 1, 0,  1, 11, 32'h0,        32'h0,        1, 1, 0));
    tab.push_back(mk(1, 1, 2, 32'hAABBCCDD, 4'hF, 0, 0, 0,  0, 0,  32'h0,        32'h0,        0, 0, 0));
    tab.push_back(mk(1, 1, 2, 32'h11223344, 4'h5, 0, 0, 0,  0, 0,  32'h0,        32'h0,        0, 0, 0));
    tab.push_back(mk(1, 0, 0, 32'h0,        4'h0, 0, 1, 2,  0, 0,  32'hAA22CC44, 32'h0,        1, 0, 0));
    tab.push_back(mk(1, 1, 5, 32'hDEADBEEF, 4'hF, 0, 1, 5,  1, 2,  32'hDEADBEEF, 32'hAA22CC44, 1, 1, 0));
    tab.push_back(mk(1, 1, 7, 32'h12345678, 4'hF, 1, 1, 7,  0, 0,  32'h0,        32'hAA22CC44, 1, 0, 0));
    tab.push_back(mk(1, 0, 0, 32'h0,        4'h0, 0, 1, 7,  1, 5,  32'h0,        32'h0,        1, 1, 0));
    tab.push_back(mk(1, 1, 2, 32'hAABBCCDD, 4'hF, 0, 0, 0,  0, 0,  32'h0,        32'h0,        0, 0, 0));
    tab.push_back(mk(1, 1, 2, 32'h11223344, 4'h5, 0, 0, 0,  0, 0,  32'h0,        32'h0,        0, 0, 0));
    tab.push_back(mk(1, 1, 13, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 1, 14, 32'h0,        32'h0,        0, 1, 1));
    tab.push_back(mk(1, 0, 0, 32'h0,        4'h0, 0, 0, 0,  0, 0,  32'h0,        32'h0,        0, 0, 0));
    tab.push_back(mk(1, 0, 0, 32'h0,        4'h0, 0, 1, 2,  1, 1,  32'hAA22CC44, 32'h0,        1, 1, 0));
    tab.push_back(mk(1, 1, 2, 32'h0,        4'h0, 0, 0, 15, 0, 15, 32'hAA22CC44, 32'h0,        0, 0, 0));
    tab.push_back(mk(1, 0, 15, 32'h0,       4'hF, 0, 1, 2,  0, 0,  32'hAA22CC44, 32'h0,        1, 0, 0));
    tab.push_back(mk(0, 1, 2, 32'hFFFFFFFF, 4'hF, 0, 1, 2,  1, 2,  32'h0,        32'h0,        0, 0, 0));
    tab.push_back(mk(1, 0, 0, 32'h0,        4'h0, 0, 1, 2,  0, 0,  32'h0,        32'h0,        1, 0, 0));

    for (int i = 0; i < tab.size(); i++) apply(tab[i], 1'b1, $sformatf("vec%0d", i));

    for (int i = 0; i < 600; i++) begin
      v.rst_n = ($urandom_range(0, 49) != 0);
      v.we    = $urandom_range(0, 1);
      v.wa    = AW'($urandom_range(0, 15));
      v.wd    = $urandom;
      v.be    = 4'($urandom_range(0, 15));
      v.clr   = ($urandom_range(0, 29) == 0);
      v.rea   = $urandom_range(0, 1);
      v.ra    = ($urandom_range(0, 3) == 0) ? v.wa : AW'($urandom_range(0, 15));
      v.reb   = $urandom_range(0, 1);
      v.rb    = ($urandom_range(0, 3) == 0) ? v.wa : AW'($urandom_range(0, 15));
      v.ea = '0; v.eb = '0; v.eva = 0; v.evb = 0; v.eerr = 0;
      apply(v, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
